// File: rtl/pla_arb_pkg.sv
// ----------------------------------------------------------------------------
// pla_arb_pkg
// Shared definitions for the priority-chain arbiter slice.
//   arb_state_t  : arbiter FSM state (IDLE, BUSY)
//   DEF_N_REQ    : default number of requesters
//   DEF_HOLD_MAX : default maximum grant hold time in cycles
//   HOLD_CNT_W   : width of the hold watchdog counter
// ----------------------------------------------------------------------------
package pla_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int DEF_N_REQ    = 5;
   localparam int DEF_HOLD_MAX = 15;
   localparam int HOLD_CNT_W   = 8;

endpackage : pla_arb_pkg

// File: rtl/pla_prio_chain.sv
// ----------------------------------------------------------------------------
// pla_prio_chain
// Purely combinational rotated generate/propagate priority chain. The
// requester at index ptr has highest priority, then ptr+1, ... wrapping
// from N_REQ-1 back to 0.
// Ports:
//   req [N_REQ-1:0] : request vector
//   ptr [ID_W-1:0]  : index of the highest-priority requester
//   win [N_REQ-1:0] : one-hot winner (all zero when req == 0)
// ----------------------------------------------------------------------------
module pla_prio_chain
   import pla_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = $clog2(DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] win
);

   logic [N_REQ-1:0] masked_s;
   logic [N_REQ-1:0] win_lo_s;
   logic [N_REQ-1:0] win_hi_s;
   logic             carry_s;

   // Two passes over the chain unroll the rotation without a barrel shifter:
   // the first pass sees only requesters at or above ptr, the second pass sees
   // every requester but is killed by any carry (grant) left by the first.
   always_comb begin
      masked_s = '0;
      win_lo_s = '0;
      win_hi_s = '0;
      carry_s  = 1'b0;
      for (int p = 0; p < N_REQ; p++) begin
         masked_s[p] = req[p] & (p >= int'(ptr));
      end
      for (int p = 0; p < N_REQ; p++) begin
         win_lo_s[p] = masked_s[p] & ~carry_s;
         carry_s     = carry_s | masked_s[p];
      end
      for (int p = 0; p < N_REQ; p++) begin
         win_hi_s[p] = req[p] & ~carry_s;
         carry_s     = carry_s | req[p];
      end
   end

   assign win = win_lo_s | win_hi_s;

endmodule : pla_prio_chain

// File: rtl/pla_chain_arbiter.sv
// ----------------------------------------------------------------------------
// pla_chain_arbiter
// Round-robin arbiter built on a rotated priority chain. A grant is issued one
// cycle after requests are sampled in IDLE and is held, ignoring req, until
// the owner pulses rel. At least one IDLE cycle separates grants.
// Optional feature macro: PLA_ARB_TIMEOUT_EN enables a hold watchdog that
// forces a release after HOLD_MAX BUSY cycles and pulses tmo.
// Ports:
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   req  [N_REQ-1:0] : level-sensitive request lines
//   rel              : release pulse from the current owner
//   gnt  [N_REQ-1:0] : registered one-hot grant
//   gnt_id [ID_W-1:0]: binary index of the owner (0 when no grant)
//   busy             : a grant is held
//   tmo              : one-cycle pulse after a forced release
// ----------------------------------------------------------------------------
module pla_chain_arbiter
   import pla_arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int HOLD_MAX = DEF_HOLD_MAX
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic                       rel,
   output logic [N_REQ-1:0]           gnt,
   output logic [$clog2(N_REQ)-1:0]   gnt_id,
   output logic                       busy,
   output logic                       tmo
);

   localparam int ID_W = $clog2(N_REQ);

   arb_state_t       state_r;
   arb_state_t       next_state_s;
   logic [ID_W-1:0]  ptr_r;
   logic [N_REQ-1:0] gnt_r;
   logic [ID_W-1:0]  gnt_id_r;
   logic             busy_r;
   logic             tmo_r;

   logic [N_REQ-1:0] win_s;
   logic [ID_W-1:0]  win_idx_s;
   logic [ID_W-1:0]  nxt_ptr_s;
   logic             load_s;
   logic             clear_s;
   logic             tmo_next_s;

`ifdef PLA_ARB_TIMEOUT_EN
   logic [HOLD_CNT_W-1:0] hold_cnt_r;
   logic                  hold_expired_s;

   // The counter reads 0 in the first BUSY cycle, so reaching HOLD_MAX-1
   // marks the last of HOLD_MAX BUSY cycles.
   assign hold_expired_s = (hold_cnt_r == HOLD_CNT_W'(HOLD_MAX - 1));
`else
   localparam int unused_hold_max = HOLD_MAX;
`endif

   pla_prio_chain #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_chain (
      .req (req),
      .ptr (ptr_r),
      .win (win_s)
   );

   // One-hot to binary encode of the chain winner.
   always_comb begin
      win_idx_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         win_idx_s = win_idx_s | (win_s[i] ? ID_W'(i) : ID_W'(0));
      end
   end

   assign nxt_ptr_s = (win_idx_s == ID_W'(N_REQ - 1)) ? ID_W'(0)
                                                      : win_idx_s + ID_W'(1);

   // Next-state and grant load/clear decisions.
   always_comb begin
      next_state_s = state_r;
      load_s       = 1'b0;
      clear_s      = 1'b0;
      tmo_next_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (|req) begin
               next_state_s = BUSY;
               load_s       = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY: begin
            if (rel) begin
               next_state_s = IDLE;
               clear_s      = 1'b1;
`ifdef PLA_ARB_TIMEOUT_EN
            end else if (hold_expired_s) begin
               next_state_s = IDLE;
               clear_s      = 1'b1;
               tmo_next_s   = 1'b1;
`endif
            end else begin
               next_state_s = BUSY;
            end
         end
         default: begin
            next_state_s = IDLE;
            clear_s      = 1'b1;
         end
      endcase
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         ptr_r    <= '0;
         gnt_r    <= '0;
         gnt_id_r <= '0;
         busy_r   <= 1'b0;
         tmo_r    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         tmo_r   <= tmo_next_s;
         if (load_s) begin
            gnt_r    <= win_s;
            gnt_id_r <= win_idx_s;
            busy_r   <= 1'b1;
            ptr_r    <= nxt_ptr_s;
         end else if (clear_s) begin
            gnt_r    <= '0;
            gnt_id_r <= '0;
            busy_r   <= 1'b0;
         end
      end
   end

`ifdef PLA_ARB_TIMEOUT_EN
   // Hold watchdog: cleared when a grant is loaded, counts BUSY cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= '0;
      end else if (load_s) begin
         hold_cnt_r <= '0;
      end else if (state_r == BUSY) begin
         hold_cnt_r <= hold_cnt_r + HOLD_CNT_W'(1);
      end
   end
`endif

   assign gnt    = gnt_r;
   assign gnt_id = gnt_id_r;
   assign busy   = busy_r;
   assign tmo    = tmo_r;

endmodule : pla_chain_arbiter

// File: tb/tb_pla_chain_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pla_chain_arbiter
// Directed self-checking bench for pla_chain_arbiter (N_REQ=5, HOLD_MAX=15).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_pla_chain_arbiter;

   logic       clk;
   logic       rst_n;
   logic [4:0] req;
   logic       rel;
   logic [4:0] gnt;
   logic [2:0] gnt_id;
   logic       busy;
   logic       tmo;

   int n_checks;
   int n_fail;

   pla_chain_arbiter #(
      .N_REQ    (5),
      .HOLD_MAX (15)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .rel    (rel),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .busy   (busy),
      .tmo    (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 5'b00000;
      rel   = 1'b0;
      #3;
      n_checks++;
      if ({gnt, gnt_id, busy, tmo} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt=%b id=%0d busy=%b tmo=%b, required all 0",
                  gnt, gnt_id, busy, tmo);
      end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if ({gnt, busy, tmo} !== 7'd0) begin
            n_fail++;
            $display("FAIL idle_cycle%0d: gnt=%b busy=%b tmo=%b, required 0/0/0",
                     c, gnt, busy, tmo);
         end
      end
   endtask

   // ptr=0, req=10100 -> 2 wins; then ptr=3 -> 4 wins. Leaves ptr=0.
   task automatic test_basic();
      req = 5'b10100;
      tick();
      n_checks++;
      if (gnt !== 5'b00100 || gnt_id !== 3'd2 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_first: gnt=%b id=%0d busy=%b, required 00100/2/1",
                  gnt, gnt_id, busy);
      end
      rel = 1'b1;
      tick();
      rel = 1'b0;
      n_checks++;
      if (gnt !== 5'b00000 || gnt_id !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_release: gnt=%b id=%0d busy=%b, required 00000/0/0",
                  gnt, gnt_id, busy);
      end
      tick();
      n_checks++;
      if (gnt !== 5'b10000 || gnt_id !== 3'd4) begin
         n_fail++;
         $display("FAIL basic_second: gnt=%b id=%0d, required 10000/4", gnt, gnt_id);
      end
      rel = 1'b1;
      req = 5'b00000;
      tick();
      rel = 1'b0;
   endtask

   // All requesting, release right after each grant. Leaves ptr=1.
   task automatic test_round_robin();
      logic [4:0] exp_g;
      req = 5'b11111;
      for (int g = 0; g < 6; g++) begin
         tick();
         exp_g = 5'b00001 << (g % 5);
         n_checks++;
         if (gnt !== exp_g || gnt_id !== 3'(g % 5) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_grant%0d: gnt=%b id=%0d busy=%b, required %b/%0d/1",
                     g, gnt, gnt_id, busy, exp_g, g % 5);
         end
         rel = 1'b1;
         tick();
         rel = 1'b0;
         n_checks++;
         if (gnt !== 5'b00000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_gap%0d: gnt=%b busy=%b, required 00000/0", g, gnt, busy);
         end
      end
      req = 5'b00000;
      tick();
   endtask

   // Owner drops req and other lines toggle while BUSY. Leaves ptr=2.
   task automatic test_owner_drop();
      req = 5'b00010;
      tick();
      n_checks++;
      if (gnt !== 5'b00010 || gnt_id !== 3'd1) begin
         n_fail++;
         $display("FAIL drop_grant: gnt=%b id=%0d, required 00010/1", gnt, gnt_id);
      end
      for (int c = 0; c < 5; c++) begin
         req = (c == 2) ? 5'b11101 : 5'b00000;
         tick();
         n_checks++;
         if (gnt !== 5'b00010 || gnt_id !== 3'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_hold%0d: gnt=%b id=%0d busy=%b, required 00010/1/1",
                     c, gnt, gnt_id, busy);
         end
      end
      req = 5'b00000;
      rel = 1'b1;
      tick();
      rel = 1'b0;
      n_checks++;
      if (gnt !== 5'b00000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_release: gnt=%b busy=%b, required 00000/0", gnt, busy);
      end
   endtask

   // Lone requester below ptr still wins; rel in IDLE has no effect. Leaves ptr=1.
   task automatic test_single();
      req = 5'b00001;
      tick();
      n_checks++;
      if (gnt !== 5'b00001 || gnt_id !== 3'd0) begin
         n_fail++;
         $display("FAIL single_win: gnt=%b id=%0d, required 00001/0", gnt, gnt_id);
      end
      rel = 1'b1;
      req = 5'b00000;
      tick();
      tick();
      tick();
      n_checks++;
      if ({gnt, busy, tmo} !== 7'd0) begin
         n_fail++;
         $display("FAIL rel_in_idle: gnt=%b busy=%b tmo=%b, required 0/0/0", gnt, busy, tmo);
      end
      rel = 1'b0;
   endtask

   // Hold watchdog (or its absence). Entered with ptr=1.
   task automatic test_timeout();
      req = 5'b00010;
      tick();
      n_checks++;
      if (gnt !== 5'b00010 || gnt_id !== 3'd1) begin
         n_fail++;
         $display("FAIL tmo_grant: gnt=%b id=%0d, required 00010/1", gnt, gnt_id);
      end
      req = 5'b00110;
`ifdef PLA_ARB_TIMEOUT_EN
      for (int c = 1; c < 15; c++) begin
         tick();
         n_checks++;
         if (gnt !== 5'b00010 || tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_hold%0d: gnt=%b tmo=%b, required 00010/0", c, gnt, tmo);
         end
      end
      tick();
      n_checks++;
      if (gnt !== 5'b00000 || busy !== 1'b0 || tmo !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_fire: gnt=%b busy=%b tmo=%b, required 00000/0/1", gnt, busy, tmo);
      end
      tick();
      n_checks++;
      if (gnt !== 5'b00100 || gnt_id !== 3'd2 || tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_next: gnt=%b id=%0d tmo=%b, required 00100/2/0", gnt, gnt_id, tmo);
      end
      rel = 1'b1;
      req = 5'b01000;
      tick();
      rel = 1'b0;
      tick();
      // rel arrives exactly at the watchdog limit: normal release, no tmo
      for (int c = 1; c < 15; c++) begin
         tick();
      end
      rel = 1'b1;
      req = 5'b00000;
      tick();
      rel = 1'b0;
      n_checks++;
      if (gnt !== 5'b00000 || tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_coincide: gnt=%b tmo=%b, required 00000/0", gnt, tmo);
      end
      tick();
      n_checks++;
      if (tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_coincide_late: tmo=%b, required 0", tmo);
      end
`else
      for (int c = 1; c < 25; c++) begin
         tick();
         n_checks++;
         if (gnt !== 5'b00010 || busy !== 1'b1 || tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL notmo_hold%0d: gnt=%b busy=%b tmo=%b, required 00010/1/0",
                     c, gnt, busy, tmo);
         end
      end
      rel = 1'b1;
      req = 5'b00000;
      tick();
      rel = 1'b0;
      n_checks++;
      if (gnt !== 5'b00000 || tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL notmo_release: gnt=%b tmo=%b, required 00000/0", gnt, tmo);
      end
`endif
   endtask

   // Reset mid-grant: immediate drop, no tmo, ptr back to 0.
   task automatic test_reset_mid();
      req = 5'b01000;
      tick();
      n_checks++;
      if (gnt !== 5'b01000 || gnt_id !== 3'd3) begin
         n_fail++;
         $display("FAIL rmid_grant: gnt=%b id=%0d, required 01000/3", gnt, gnt_id);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (gnt !== 5'b00000 || gnt_id !== 3'd0 || busy !== 1'b0 || tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_async: gnt=%b id=%0d busy=%b tmo=%b, required 0/0/0/0",
                  gnt, gnt_id, busy, tmo);
      end
      tick();
      rst_n = 1'b1;
      req   = 5'b11000;
      tick();
      // ptr=0 picks 3; a stale ptr of 4 would pick 4
      n_checks++;
      if (gnt !== 5'b01000 || gnt_id !== 3'd3 || tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_post: gnt=%b id=%0d tmo=%b, required 01000/3/0", gnt, gnt_id, tmo);
      end
      rel = 1'b1;
      req = 5'b00000;
      tick();
      rel = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_idle();
      test_basic();
      test_round_robin();
      test_owner_drop();
      test_single();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pla_chain_arbiter
